// File: rtl/local_history_predictor.sv
// Fetch-stage conditional-branch direction predictor with per-slot local history.
//
// Each fetch slot owns a committed local-history table (CH), a speculative
// history overlay (SH with valid SV), a trained flag per entry (TR) and a
// 2-bit saturating pattern table (PHT). Untrained entries fall back to
// backward-taken. EX-stage resolution trains CH/PHT; a misprediction clears
// every speculative overlay.
//
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   en           fetch advances; gates speculative history updates
//   pc_now       current fetch PC (group aligned to FETCH_WIDTH*4 bytes)
//   btb_hit      per-slot "known conditional branch"
//   btb_target   per-slot targets, slot s in [s*ADDR_WIDTH +: ADDR_WIDTH]
//   ex_vld       a conditional branch resolved in EX
//   ex_pc        PC of the resolved branch
//   ex_taken     resolved direction
//   ex_wrong     prediction was wrong; flush speculative history
//   pc_new       next fetch PC
//   branch       a taken branch was predicted in this group
//   slot         lowest predicted-taken active slot (0 when branch=0)
//
// Optional build macro PRED_STATS_EN adds saturating 32-bit counters
// stat_pred (resolved branches) and stat_miss (mispredictions).
module local_history_predictor #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned IDX_DEPTH   = 5,
  parameter int unsigned HIST_LEN    = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              en,
  input  logic [ADDR_WIDTH-1:0]             pc_now,
  input  logic [FETCH_WIDTH-1:0]            btb_hit,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] btb_target,
  input  logic                              ex_vld,
  input  logic [ADDR_WIDTH-1:0]             ex_pc,
  input  logic                              ex_taken,
  input  logic                              ex_wrong,
  output logic [ADDR_WIDTH-1:0]             pc_new,
  output logic                              branch,
  output logic [((FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1)-1:0] slot
`ifdef PRED_STATS_EN
  ,
  output logic [31:0]                       stat_pred,
  output logic [31:0]                       stat_miss
`endif
);

  localparam int unsigned G    = $clog2(FETCH_WIDTH);
  localparam int unsigned SW   = (G > 0) ? G : 1;
  localparam int unsigned ENT  = 1 << IDX_DEPTH;
  localparam int unsigned PENT = 1 << HIST_LEN;
  localparam int unsigned PW   = ADDR_WIDTH - 2;      // word address width
  localparam int unsigned GW   = ADDR_WIDTH - G - 2;  // group address width

  logic [HIST_LEN-1:0] ch_q  [FETCH_WIDTH][ENT];
  logic [HIST_LEN-1:0] sh_q  [FETCH_WIDTH][ENT];
  logic [ENT-1:0]      sv_q  [FETCH_WIDTH];
  logic [ENT-1:0]      tr_q  [FETCH_WIDTH];
  logic [1:0]          pht_q [FETCH_WIDTH][PENT];

  logic [PW-1:0]        spc    [FETCH_WIDTH];
  logic [PW-1:0]        tgt_w  [FETCH_WIDTH];
  logic [IDX_DEPTH-1:0] ent    [FETCH_WIDTH];
  logic [HIST_LEN-1:0]  hist   [FETCH_WIDTH];
  logic [HIST_LEN-1:0]  pidx   [FETCH_WIDTH];
  logic [HIST_LEN-1:0]  sh_nxt [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] dir, upd;
  logic [G-1:0]         start;
  logic [GW-1:0]        grp_next;
  logic                 blocked;
  logic                 act;

  logic [G-1:0]         se;
  logic [IDX_DEPTH-1:0] ee;
  logic [HIST_LEN-1:0]  cidx;
  logic [1:0]           cnt, cnt_nxt;

  logic unused_bits;
  assign unused_bits = ^{pc_now[1:0], ex_pc, btb_target};

  // Lookup and selection. "blocked" goes high at the first taken slot, so
  // later slots neither win selection nor receive a speculative update.
  always_comb begin
    start    = pc_now[G+1:2];
    grp_next = pc_now[ADDR_WIDTH-1:G+2] + GW'(1);
    branch   = 1'b0;
    slot     = '0;
    pc_new   = {grp_next, {(G+2){1'b0}}};
    blocked  = 1'b0;
    act      = 1'b0;
    dir      = '0;
    upd      = '0;
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      spc[s]    = {pc_now[ADDR_WIDTH-1:G+2], G'(s)};
      tgt_w[s]  = btb_target[s*ADDR_WIDTH+2 +: PW];
      ent[s]    = spc[s][IDX_DEPTH+G-1:G];
      hist[s]   = sv_q[s][ent[s]] ? sh_q[s][ent[s]] : ch_q[s][ent[s]];
      pidx[s]   = hist[s] ^ spc[s][HIST_LEN-1:0];
      dir[s]    = tr_q[s][ent[s]] ? pht_q[s][pidx[s]][1] : (tgt_w[s] < spc[s]);
      sh_nxt[s] = {hist[s][HIST_LEN-2:0], dir[s]};
      act       = (G'(s) >= start) && btb_hit[s];
      upd[s]    = act && tr_q[s][ent[s]] && !blocked;
      if (act && dir[s] && !blocked) begin
        branch  = 1'b1;
        slot    = SW'(s);
        pc_new  = {tgt_w[s], 2'b00};
        blocked = 1'b1;
      end
    end
  end

  // EX training uses the committed history as it stood before this edge.
  always_comb begin
    se      = ex_pc[G+1:2];
    ee      = ex_pc[IDX_DEPTH+G+1:G+2];
    cidx    = ch_q[se][ee] ^ ex_pc[HIST_LEN+1:2];
    cnt     = pht_q[se][cidx];
    cnt_nxt = cnt;
    if (ex_taken && cnt != 2'b11) begin
      cnt_nxt = cnt + 2'd1;
    end else if (!ex_taken && cnt != 2'b00) begin
      cnt_nxt = cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < FETCH_WIDTH; s++) begin
        sv_q[s] <= '0;
        tr_q[s] <= '0;
        for (int e = 0; e < ENT; e++) begin
          ch_q[s][e] <= '0;
          sh_q[s][e] <= '0;
        end
        for (int p = 0; p < PENT; p++) begin
          pht_q[s][p] <= 2'b01;
        end
      end
    end else begin
      if (en) begin
        for (int s = 0; s < FETCH_WIDTH; s++) begin
          if (upd[s]) begin
            sh_q[s][ent[s]] <= sh_nxt[s];
            sv_q[s][ent[s]] <= 1'b1;
          end
        end
      end
      if (ex_vld) begin
        ch_q[se][ee]    <= {ch_q[se][ee][HIST_LEN-2:0], ex_taken};
        tr_q[se][ee]    <= 1'b1;
        pht_q[se][cidx] <= cnt_nxt;
        // Placed after the speculative set so the flush wins on the same edge.
        if (ex_wrong) begin
          for (int s = 0; s < FETCH_WIDTH; s++) begin
            sv_q[s] <= '0;
          end
        end
      end
    end
  end

`ifdef PRED_STATS_EN
  logic [31:0] stat_pred_q, stat_miss_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_pred_q <= '0;
      stat_miss_q <= '0;
    end else if (ex_vld) begin
      if (stat_pred_q != 32'hFFFF_FFFF) stat_pred_q <= stat_pred_q + 32'd1;
      if (ex_wrong && stat_miss_q != 32'hFFFF_FFFF) stat_miss_q <= stat_miss_q + 32'd1;
    end
  end

  assign stat_pred = stat_pred_q;
  assign stat_miss = stat_miss_q;
`endif

endmodule
